// File: rtl/agc_pkg.sv
// Shared AGC definitions: sample format, detector state encoding and counter sizing.
package agc_pkg;

   localparam int unsigned MAG_W = 4;
   localparam logic [MAG_W-1:0] MIDSCALE = 4'd8;

   localparam int unsigned STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_BLANK = 2'd1;
   localparam logic [STATE_W-1:0] ST_ACCUM = 2'd2;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/overload_detector_if.sv
// Sample/decision bundle between the VGA/AGC side and the overload detector.
interface overload_detector_if;
   import agc_pkg::*;

   logic [MAG_W-1:0] amplified_signal;
   logic             sample_valid;
   logic [MAG_W-1:0] threshold;
   logic             enable;
   logic             gain_change;
   logic             overload;
   logic [MAG_W-1:0] peak_out;
   logic             window_done;

   modport master (
      output amplified_signal, sample_valid, threshold, enable, gain_change,
      input  overload, peak_out, window_done
   );

   modport slave (
      input  amplified_signal, sample_valid, threshold, enable, gain_change,
      output overload, peak_out, window_done
   );

endinterface

// File: rtl/sample_mag.sv
// Distance of an offset-binary sample code from midscale.
module sample_mag
   import agc_pkg::*;
(
   input  logic [MAG_W-1:0] code,
   output logic [MAG_W-1:0] mag_c
);

   always_comb begin
      mag_c = (code >= MIDSCALE) ? code - MIDSCALE : MIDSCALE - code;
   end

endmodule

// File: rtl/overload_detector.sv
// Windowed overload detector: counts threshold hits per WINDOW_LEN valid samples,
// blanking the input for BLANK_CYCLES after every gain change.
module overload_detector
   import agc_pkg::*;
#(
   parameter int unsigned WINDOW_LEN   = 16,
   parameter int unsigned HIT_COUNT    = 2,
   parameter int unsigned BLANK_CYCLES = 4
) (
   input  logic                clk,
   input  logic                RESET,
   overload_detector_if.slave  bus
);

   localparam int unsigned CNT_W = cnt_width(WINDOW_LEN);
   localparam int unsigned BLK_W = cnt_width(BLANK_CYCLES);

   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW_LEN - 1);
   localparam logic [CNT_W-1:0] HIT_MAX     = CNT_W'(WINDOW_LEN);
   localparam logic [CNT_W-1:0] HIT_MIN     = CNT_W'(HIT_COUNT);
   localparam logic [BLK_W-1:0] BLANK_LAST  = BLK_W'(BLANK_CYCLES - 1);

   logic [STATE_W-1:0] state,      state_nxt;
   logic [BLK_W-1:0]   blank_cnt,  blank_nxt;
   logic [CNT_W-1:0]   sample_cnt, sample_nxt;
   logic [CNT_W-1:0]   hit_cnt,    hit_nxt;
   logic [MAG_W-1:0]   peak_run,   peak_run_nxt;
   logic               overload_q, overload_nxt;
   logic [MAG_W-1:0]   peak_q,     peak_nxt;
   logic               done_q,     done_nxt;

   logic [MAG_W-1:0]   mag_c;
   logic               hit_c;
   logic [CNT_W-1:0]   hit_sum_c;
   logic [MAG_W-1:0]   peak_sum_c;

   sample_mag u_mag (
      .code  (bus.amplified_signal),
      .mag_c (mag_c)
   );

   // Running totals as they would stand if the current sample is accepted.
   assign hit_c      = bus.sample_valid && (mag_c >= bus.threshold);
   assign hit_sum_c  = (hit_c && (hit_cnt != HIT_MAX)) ? hit_cnt + CNT_W'(1) : hit_cnt;
   assign peak_sum_c = (mag_c > peak_run) ? mag_c : peak_run;

   always_comb begin
      state_nxt    = state;
      blank_nxt    = blank_cnt;
      sample_nxt   = sample_cnt;
      hit_nxt      = hit_cnt;
      peak_run_nxt = peak_run;
      overload_nxt = overload_q;
      peak_nxt     = peak_q;
      done_nxt     = 1'b0;

      if (!bus.enable) begin
         state_nxt    = ST_IDLE;
         blank_nxt    = '0;
         sample_nxt   = '0;
         hit_nxt      = '0;
         peak_run_nxt = '0;
         overload_nxt = 1'b0;
         peak_nxt     = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_BLANK;
               blank_nxt = '0;
            end
            ST_BLANK: begin
               if (bus.gain_change) begin
                  blank_nxt = '0;
               end else if (blank_cnt == BLANK_LAST) begin
                  state_nxt    = ST_ACCUM;
                  sample_nxt   = '0;
                  hit_nxt      = '0;
                  peak_run_nxt = '0;
               end else begin
                  blank_nxt = blank_cnt + BLK_W'(1);
               end
            end
            ST_ACCUM: begin
               // A gain change invalidates the partial window, even on its last sample.
               if (bus.gain_change) begin
                  state_nxt    = ST_BLANK;
                  blank_nxt    = '0;
                  sample_nxt   = '0;
                  hit_nxt      = '0;
                  peak_run_nxt = '0;
               end else if (bus.sample_valid) begin
                  if (sample_cnt == LAST_SAMPLE) begin
                     overload_nxt = (hit_sum_c >= HIT_MIN);
                     peak_nxt     = peak_sum_c;
                     done_nxt     = 1'b1;
                     sample_nxt   = '0;
                     hit_nxt      = '0;
                     peak_run_nxt = '0;
                  end else begin
                     sample_nxt   = sample_cnt + CNT_W'(1);
                     hit_nxt      = hit_sum_c;
                     peak_run_nxt = peak_sum_c;
                  end
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state      <= ST_IDLE;
         blank_cnt  <= '0;
         sample_cnt <= '0;
         hit_cnt    <= '0;
         peak_run   <= '0;
         overload_q <= 1'b0;
         peak_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_nxt;
         blank_cnt  <= blank_nxt;
         sample_cnt <= sample_nxt;
         hit_cnt    <= hit_nxt;
         peak_run   <= peak_run_nxt;
         overload_q <= overload_nxt;
         peak_q     <= peak_nxt;
         done_q     <= done_nxt;
      end
   end

   assign bus.overload    = overload_q;
   assign bus.peak_out    = peak_q;
   assign bus.window_done = done_q;

endmodule

// File: tb/tb_overload_detector.sv
// Scoreboard bench for overload_detector: directed scenarios then random traffic,
// predicted by a window-list model and checked by an independent negedge monitor.
module tb_overload_detector;

   localparam int W  = 16;
   localparam int HC = 2;
   localparam int B  = 4;

   logic clk   = 1'b0;
   logic RESET = 1'b1;
   always #5 clk = ~clk;

   overload_detector_if bus ();

   overload_detector #(
      .WINDOW_LEN   (W),
      .HIT_COUNT    (HC),
      .BLANK_CYCLES (B)
   ) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   typedef struct {
      int edge_no;
      int ov;
      int pk;
   } exp_t;
   exp_t sb[$];

   // Reference model: the open window is kept as a list of (magnitude, hit) pairs.
   bit m_active;
   int m_blank;
   int m_mag[$];
   bit m_hit[$];
   int exp_ov;
   int exp_pk;

   always @(posedge clk) edge_n++;

   function automatic int mag_of(input int code);
      return (code >= 8) ? code - 8 : 8 - code;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   task automatic model_clear();
      m_mag.delete();
      m_hit.delete();
   endtask

   // Predict the effect of the coming rising edge for the given inputs.
   task automatic model_edge(input bit en, input bit v, input bit gc, input int code, input int th);
      int h;
      int p;
      exp_t e;
      if (!en) begin
         m_active = 1'b0;
         model_clear();
         exp_ov = 0;
         exp_pk = 0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_blank  = B;
         model_clear();
      end else if (gc) begin
         m_blank = B;
         model_clear();
      end else if (m_blank > 0) begin
         m_blank--;
      end else if (v) begin
         m_mag.push_back(mag_of(code));
         m_hit.push_back(mag_of(code) >= th);
         if (m_mag.size() == W) begin
            h = 0;
            p = 0;
            foreach (m_mag[i]) begin
               if (m_hit[i]) h++;
               if (m_mag[i] > p) p = m_mag[i];
            end
            e.edge_no = edge_n + 1;
            e.ov      = (h >= HC) ? 1 : 0;
            e.pk      = p;
            sb.push_back(e);
            exp_ov = e.ov;
            exp_pk = e.pk;
            model_clear();
         end
      end
   endtask

   task automatic step(input bit en, input bit v, input bit gc, input int code, input int th);
      @(negedge clk);
      #1;
      bus.enable           = en;
      bus.sample_valid     = v;
      bus.gain_change      = gc;
      bus.amplified_signal = 4'(code);
      bus.threshold        = 4'(th);
      model_edge(en, v, gc, code, th);
   endtask

   task automatic samples(input int n, input int code);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, code, 6);
   endtask

   task automatic idle_en(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8, 6);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      RESET                = 1'b1;
      bus.enable           = 1'b0;
      bus.sample_valid     = 1'b0;
      bus.gain_change      = 1'b0;
      bus.amplified_signal = 4'd8;
      bus.threshold        = 4'd6;
      m_active = 1'b0;
      model_clear();
      exp_ov = 0;
      exp_pk = 0;
      sb.delete();
      #1;
      chk("rst_overload", int'(bus.overload), 0);
      chk("rst_peak_out", int'(bus.peak_out), 0);
      chk("rst_window_done", int'(bus.window_done), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      RESET = 1'b0;
      model_edge(1'b0, 1'b0, 1'b0, 8, 6);
   endtask

   // Monitor: every cycle compares outputs with the model and pops finished windows.
   initial begin : monitor
      exp_t e;
      int   exp_wd;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].edge_no < edge_n) void'(sb.pop_front());
         exp_wd = (sb.size() > 0 && sb[0].edge_no == edge_n) ? 1 : 0;
         chk("window_done", int'(bus.window_done), exp_wd);
         if (exp_wd == 1 && bus.window_done === 1'b1) begin
            e = sb.pop_front();
            chk("win_overload", int'(bus.overload), e.ov);
            chk("win_peak_out", int'(bus.peak_out), e.pk);
         end
         chk("overload", int'(bus.overload), exp_ov);
         chk("peak_out", int'(bus.peak_out), exp_pk);
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int th;
      bus.enable           = 1'b0;
      bus.sample_valid     = 1'b0;
      bus.gain_change      = 1'b0;
      bus.amplified_signal = 4'd8;
      bus.threshold        = 4'd6;
      m_active = 1'b0;
      exp_ov   = 0;
      exp_pk   = 0;
      do_reset();

      // Quiet window, then two-hit and one-hit windows.
      idle_en(1 + B);
      samples(W, 8);
      samples(2, 15);
      samples(W - 2, 8);
      samples(1, 15);
      samples(W - 1, 8);

      // Hits exactly at threshold and a full-scale negative sample.
      samples(1, 2);
      samples(1, 14);
      samples(1, 0);
      samples(W - 3, 8);

      // Gain change mid-window: partial window dropped, blanked samples ignored.
      samples(10, 15);
      step(1'b1, 1'b1, 1'b1, 15, 6);
      samples(B, 15);
      samples(W, 8);

      // Gain change on the last sample of a window.
      samples(W - 1, 15);
      step(1'b1, 1'b1, 1'b1, 15, 6);
      idle_en(B);
      samples(W, 0);

      // Gain change while disabled, then re-enable.
      step(1'b0, 1'b1, 1'b1, 15, 6);
      step(1'b0, 1'b0, 1'b1, 8, 6);
      idle_en(1 + B);

      // Valid every other cycle.
      for (int i = 0; i < 2 * W; i++) step(1'b1, (i % 2) == 0, 1'b0, 15, 6);

      // Enable dropped mid-window after an overloaded window.
      samples(W, 15);
      samples(5, 15);
      step(1'b0, 1'b1, 1'b0, 15, 6);
      idle_en(1 + B);
      samples(W, 15);
      samples(5, 15);
      do_reset();

      // Random traffic.
      th = 6;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 999) < 2) begin
            do_reset();
         end else begin
            if ($urandom_range(0, 99) < 4) th = $urandom_range(0, 15);
            step($urandom_range(0, 999) >= 5,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 1,
                 $urandom_range(0, 15), th);
         end
      end

      idle_en(3);
      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/overload_detector.md
OVERLOAD_DETECTOR -- requirements
Module: overload_detector

Interface
REQ-001 Parameter WINDOW_LEN, 16, valid samples per decision window (range 2..255).
REQ-002 Parameter HIT_COUNT, 2, minimum threshold hits in a window to flag overload (range 1..WINDOW_LEN).
REQ-003 Parameter BLANK_CYCLES, 4, clock cycles of sample blanking after a gain change (range 1..255).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 amplified_signal  input  4  unsigned VGA output sample code; midscale 8 means zero signal.
REQ-007 sample_valid  input  1  amplified_signal is a valid sample this cycle.
REQ-008 threshold  input  4  magnitude at or above which a sample counts as a hit.
REQ-009 enable  input  1  detector active when high.
REQ-010 gain_change  input  1  single-cycle pulse from the AGC when vga_control changes.
REQ-011 overload  output  1  registered overload decision consumed by the AGC.
REQ-012 peak_out  output  4  maximum sample magnitude of the last completed window.
REQ-013 window_done  output  1  one-cycle pulse when overload and peak_out update.

Function
REQ-014 Magnitude SHALL be code-8 when code>=8, else 8-code; range 0..8, 4 bits, no overflow.
REQ-015 A hit SHALL be sample_valid high and magnitude >= threshold; threshold 0 makes every valid sample a hit; threshold 9..15 SHALL never hit.
REQ-016 States SHALL be IDLE, BLANK and ACCUM.
REQ-017 IDLE: samples ignored; enable high moves to BLANK on the next edge.
REQ-018 BLANK: blank counter counts every clock cycle; samples ignored; after BLANK_CYCLES cycles move to ACCUM with sample, hit and peak counters cleared.
REQ-019 ACCUM: each valid sample increments the sample count, adds to the hit count if a hit, and updates the running peak with max(peak, magnitude).
REQ-020 On the edge accepting the WINDOW_LEN-th valid sample, the detector SHALL include that sample, set overload to (hits >= HIT_COUNT), load peak_out, assert window_done for exactly one cycle, and clear the counters while staying in ACCUM.
REQ-021 Decision latency SHALL be one cycle: window_done is high in the cycle after the last sample is presented.
REQ-022 Windows SHALL be back-to-back; a valid sample in the window_done cycle counts as sample 1 of the next window.
REQ-023 Invalid cycles SHALL not advance the window; a window has no time limit.
REQ-024 Hit counter SHALL saturate at WINDOW_LEN and never wrap.
REQ-025 gain_change in BLANK or ACCUM SHALL move to BLANK, restart the blank count and discard the partial window; overload and peak_out hold.
REQ-026 gain_change coinciding with the WINDOW_LEN-th sample SHALL take priority: no window_done, overload holds, move to BLANK.
REQ-027 enable low in any state SHALL move to IDLE on the next edge, clear the counters, and clear overload and peak_out to 0; window_done SHALL stay low.
REQ-028 gain_change while enable is low SHALL be ignored.
REQ-029 threshold SHALL be sampled per cycle; changes mid-window affect only subsequent samples.

Reset
REQ-030 RESET high SHALL force state IDLE, all counters 0, overload 0, peak_out 0, window_done 0, immediately and independent of clk.
REQ-031 After reset release with enable high, the first window_done SHALL occur no earlier than 1 + BLANK_CYCLES + WINDOW_LEN cycles later.
REQ-032 Reset asserted mid-window SHALL discard the window with no window_done pulse.

Structure
REQ-033 Shared package agc_pkg SHALL hold the state enumeration, the midscale constant 8, and the magnitude width 4.
REQ-034 The magnitude computation SHALL be a combinational sub-module sample_mag (4-bit code in, 4-bit magnitude out).
REQ-035 The counter width SHALL be derived with a clog2-based function in agc_pkg.

Verification (default parameters, threshold 6)
REQ-036 Reset, enable=1, 16 valid samples of code 8 -> window_done once, overload=0, peak_out=0.
REQ-037 Window with 2 samples of code 15 (magnitude 7), rest code 8 -> overload=1, peak_out=7; window with only 1 such sample -> overload=0, peak_out=7.
REQ-038 Samples of code 2 and 14 (magnitude 6, equal to threshold) -> counted as hits; code 0 -> magnitude 8, peak_out=8.
REQ-039 gain_change after 10 samples -> no window_done, 4 cycles blanked, next window_done after 16 further valid samples; overload holds its prior value throughout.
REQ-040 gain_change on the 16th-sample cycle -> no window_done; gain_change with enable low -> no effect.
REQ-041 sample_valid toggling every other cycle -> window_done 32 cycles after window start; enable dropped mid-window -> overload=0 next cycle; RESET mid-window -> outputs 0 immediately.
